// File: rtl/falafel_req_arbiter.sv
//------------------------------------------------------------------------------
// falafel_pkg / falafel_req_arbiter
//------------------------------------------------------------------------------
// Round-robin arbiter that drains the alloc and free request FIFOs and presents
// one tagged request at a time to the allocator core over a valid/ready port.
// core_req_* outputs come straight from flops.
//
// Optional feature macro: FALAFEL_ARB_PERF_CNT_EN
//   defined   -> saturating per-type grant counters
//   undefined -> count outputs tied to zero, no counter flops
//------------------------------------------------------------------------------
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package falafel_pkg;
  // Request payload width shared by the whole falafel front end.
  localparam int DATA_W = 32;
endpackage : falafel_pkg

module falafel_req_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // alloc request FIFO (first-word-fall-through)
  input  logic                          alloc_fifo_empty_i,
  output logic                          alloc_fifo_read_o,
  input  logic [falafel_pkg::DATA_W-1:0] alloc_fifo_dout_i,
  // free request FIFO (first-word-fall-through)
  input  logic                          free_fifo_empty_i,
  output logic                          free_fifo_read_o,
  input  logic [falafel_pkg::DATA_W-1:0] free_fifo_dout_i,
  // request port to the allocator core
  output logic                          core_req_val_o,
  input  logic                          core_req_rdy_i,
  output logic                          core_req_type_o,
  output logic [falafel_pkg::DATA_W-1:0] core_req_data_o,
  // grant counters
  output logic [CNT_W-1:0]              alloc_grant_cnt_o,
  output logic [CNT_W-1:0]              free_grant_cnt_o
);

  localparam int DATA_W = falafel_pkg::DATA_W;

  // Request type encoding, also used for the round-robin priority pointer.
  localparam logic c_TYPE_ALLOC = 1'b0;
  localparam logic c_TYPE_FREE  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_prio;        // type that wins the next contended grant
  logic                r_type;
  logic [DATA_W-1:0]   r_data;

  logic                w_alloc_ne;
  logic                w_free_ne;
  logic                w_any_ne;
  logic                w_handshake;
  logic                w_take;        // output slot is empty or being emptied
  logic                w_load;        // a FIFO is popped this cycle
  logic                w_grant_free;  // winner of this cycle's grant
  logic                w_alloc_read;
  logic                w_free_read;

  // Valid is the ISSUE state itself, so it is a flop output.
  assign core_req_val_o  = (r_state == ST_ISSUE);
  assign core_req_type_o = r_type;
  assign core_req_data_o = r_data;

  assign alloc_fifo_read_o = w_alloc_read;
  assign free_fifo_read_o  = w_free_read;

  // Winner selection and pop generation for the current cycle.
  always_comb begin
    w_alloc_ne   = ~alloc_fifo_empty_i;
    w_free_ne    = ~free_fifo_empty_i;
    w_any_ne     = w_alloc_ne | w_free_ne;
    w_handshake  = core_req_val_o & core_req_rdy_i;
    // In ISSUE the slot frees up only on a handshake; IDLE has no pending request.
    w_take       = (r_state == ST_IDLE) | w_handshake;
    // Pops are held off while reset is asserted so no entry is consumed and lost.
    w_load       = w_take & w_any_ne & ~rst_i;
    // Sole non-empty FIFO wins; under contention the priority pointer decides.
    w_grant_free = w_free_ne & (~w_alloc_ne | (r_prio == c_TYPE_FREE));
    w_alloc_read = w_load & ~w_grant_free;
    w_free_read  = w_load &  w_grant_free;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: stay in ISSUE while requests keep arriving back to back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_handshake && !w_any_ne) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output request registers and priority pointer, reloaded on every grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_type <= c_TYPE_ALLOC;
      r_data <= '0;
      r_prio <= c_TYPE_ALLOC;
    end else if (w_load) begin
      r_type <= w_grant_free;
      r_data <= w_grant_free ? free_fifo_dout_i : alloc_fifo_dout_i;
      // The type that just lost (or was absent) gets the next contended grant.
      r_prio <= ~w_grant_free;
    end
  end

`ifdef FALAFEL_ARB_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_alloc_cnt;
  logic [CNT_W-1:0] r_free_cnt;

  // Saturating grant counters, one increment per FIFO pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alloc_cnt <= '0;
      r_free_cnt  <= '0;
    end else begin
      if (w_alloc_read && (r_alloc_cnt != c_CNT_MAX)) begin
        r_alloc_cnt <= r_alloc_cnt + c_CNT_ONE;
      end
      if (w_free_read && (r_free_cnt != c_CNT_MAX)) begin
        r_free_cnt <= r_free_cnt + c_CNT_ONE;
      end
    end
  end

  assign alloc_grant_cnt_o = r_alloc_cnt;
  assign free_grant_cnt_o  = r_free_cnt;
`else
  assign alloc_grant_cnt_o = '0;
  assign free_grant_cnt_o  = '0;
`endif

endmodule : falafel_req_arbiter

`default_nettype wire

// File: tb/tb_falafel_req_arbiter.sv
//------------------------------------------------------------------------------
// tb_falafel_req_arbiter
//------------------------------------------------------------------------------
// Self-checking bench: queue-based FIFO models feed the arbiter, a transaction
// level reference predicts pops, the presented request and grant counts.
//------------------------------------------------------------------------------
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_falafel_req_arbiter;

  localparam int DW = falafel_pkg::DATA_W;
  localparam int CW = 4;
`ifdef FALAFEL_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          alloc_empty;
  logic          alloc_read;
  logic [DW-1:0] alloc_dout;
  logic          free_empty;
  logic          free_read;
  logic [DW-1:0] free_dout;
  logic          core_val;
  logic          core_rdy;
  logic          core_type;
  logic [DW-1:0] core_data;
  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] free_cnt;

  falafel_req_arbiter #(.CNT_W(CW)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .alloc_fifo_empty_i (alloc_empty),
    .alloc_fifo_read_o  (alloc_read),
    .alloc_fifo_dout_i  (alloc_dout),
    .free_fifo_empty_i  (free_empty),
    .free_fifo_read_o   (free_read),
    .free_fifo_dout_i   (free_dout),
    .core_req_val_o     (core_val),
    .core_req_rdy_i     (core_rdy),
    .core_req_type_o    (core_type),
    .core_req_data_o    (core_data),
    .alloc_grant_cnt_o  (alloc_cnt),
    .free_grant_cnt_o   (free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Upstream FIFO contents and log of accepted requests ({type, data}).
  logic [DW-1:0] aq[$];
  logic [DW-1:0] fq[$];
  logic [63:0]   hs_log[$];

  // Reference: what the core should currently see and the arbitration memory.
  logic          m_val;
  logic          m_type;
  logic [DW-1:0] m_data;
  logic          m_prio_free;
  int            m_acnt;
  int            m_fcnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_pins();
    alloc_empty = (aq.size() == 0);
    free_empty  = (fq.size() == 0);
    alloc_dout  = (aq.size() != 0) ? aq[0] : '0;
    free_dout   = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_a(input logic [DW-1:0] v);
    aq.push_back(v);
    refresh_pins();
  endtask

  task automatic push_f(input logic [DW-1:0] v);
    fq.push_back(v);
    refresh_pins();
  endtask

  task automatic model_reset();
    m_val       = 1'b0;
    m_type      = 1'b0;
    m_data      = '0;
    m_prio_free = 1'b0;
    m_acnt      = 0;
    m_fcnt      = 0;
  endtask

  function automatic int sat_inc(input int c);
    return (c < CNT_MAX) ? c + 1 : c;
  endfunction

  // One clock cycle, entered just after a falling edge.
  task automatic run_cycle(input logic rdy);
    logic          e_ra, e_rf, gf, got_ra, got_rf;
    logic          n_val, n_type, n_prio;
    logic [DW-1:0] n_data;
    int            n_acnt, n_fcnt;
    core_rdy = rdy;
    #1;
    check_eq("val",  64'(core_val),  64'(m_val));
    check_eq("type", 64'(core_type), 64'(m_type));
    check_eq("data", 64'(core_data), 64'(m_data));
    check_eq("acnt", 64'(alloc_cnt), PERF ? 64'(m_acnt) : 64'd0);
    check_eq("fcnt", 64'(free_cnt),  PERF ? 64'(m_fcnt) : 64'd0);
    if (core_val && rdy) hs_log.push_back({31'd0, core_type, core_data});

    e_ra = 1'b0; e_rf = 1'b0;
    n_val = m_val; n_type = m_type; n_data = m_data; n_prio = m_prio_free;
    n_acnt = m_acnt; n_fcnt = m_fcnt;
    // A new request may be taken when nothing is pending or the pending one is accepted.
    if (!m_val || rdy) begin
      if (aq.size() != 0 || fq.size() != 0) begin
        if (aq.size() == 0)      gf = 1'b1;
        else if (fq.size() == 0) gf = 1'b0;
        else                     gf = m_prio_free;
        n_val  = 1'b1;
        n_type = gf;
        n_data = gf ? fq[0] : aq[0];
        n_prio = !gf;
        if (gf) begin e_rf = 1'b1; n_fcnt = sat_inc(m_fcnt); end
        else    begin e_ra = 1'b1; n_acnt = sat_inc(m_acnt); end
      end else begin
        n_val = 1'b0;
      end
    end
    got_ra = alloc_read;
    got_rf = free_read;
    check_eq("alloc_read", 64'(got_ra), 64'(e_ra));
    check_eq("free_read",  64'(got_rf), 64'(e_rf));

    @(posedge clk);
    #1;
    if (got_ra && aq.size() != 0) void'(aq.pop_front());
    if (got_rf && fq.size() != 0) void'(fq.pop_front());
    refresh_pins();
    m_val = n_val; m_type = n_type; m_data = n_data; m_prio_free = n_prio;
    m_acnt = n_acnt; m_fcnt = n_fcnt;
    @(negedge clk);
  endtask

  task automatic check_log(input string tag, input int idx, input logic typ, input logic [DW-1:0] d);
    if (idx < hs_log.size()) check_eq(tag, hs_log[idx], {31'd0, typ, d});
    else                     check_eq(tag, 64'hDEAD_0000_0000_0000, {31'd0, typ, d});
  endtask

  initial begin
    rst      = 1'b1;
    core_rdy = 1'b0;
    refresh_pins();
    model_reset();
    repeat (3) @(negedge clk);
    // Reset state
    check_eq("rst_val",   64'(core_val),   64'd0);
    check_eq("rst_type",  64'(core_type),  64'd0);
    check_eq("rst_data",  64'(core_data),  64'd0);
    check_eq("rst_acnt",  64'(alloc_cnt),  64'd0);
    check_eq("rst_fcnt",  64'(free_cnt),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Contention: strict alternation starting with alloc
    hs_log.delete();
    push_a(32'hA1); push_a(32'hA2); push_f(32'hF1); push_f(32'hF2);
    repeat (6) run_cycle(1'b1);
    check_eq("cont_n", 64'(hs_log.size()), 64'd4);
    check_log("cont0", 0, 1'b0, 32'hA1);
    check_log("cont1", 1, 1'b1, 32'hF1);
    check_log("cont2", 2, 1'b0, 32'hA2);
    check_log("cont3", 3, 1'b1, 32'hF2);

    // Single alloc
    hs_log.delete();
    push_a(32'h40);
    repeat (3) run_cycle(1'b1);
    check_eq("single_n", 64'(hs_log.size()), 64'd1);
    check_log("single0", 0, 1'b0, 32'h40);

    // Backpressure: request held for 5 cycles without further pops
    hs_log.delete();
    push_f(32'h1000);
    run_cycle(1'b0);
    push_f(32'h2000);
    repeat (5) run_cycle(1'b0);
    check_eq("bp_data", 64'(core_data), 64'h1000);
    check_eq("bp_fq",   64'(fq.size()), 64'd1);
    repeat (3) run_cycle(1'b1);
    check_eq("bp_n", 64'(hs_log.size()), 64'd2);
    check_log("bp0", 0, 1'b1, 32'h1000);
    check_log("bp1", 1, 1'b1, 32'h2000);

    // Drain then refill one cycle after the last handshake
    hs_log.delete();
    push_a(32'h11);
    run_cycle(1'b1);
    run_cycle(1'b1);
    push_f(32'h22);
    repeat (4) run_cycle(1'b1);
    check_eq("refill_n", 64'(hs_log.size()), 64'd2);
    check_log("refill0", 0, 1'b0, 32'h11);
    check_log("refill1", 1, 1'b1, 32'h22);

    // Reset while a request is pending
    push_a(32'h77);
    run_cycle(1'b0);
    run_cycle(1'b0);
    check_eq("pre_rst_val", 64'(core_val), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_val",  64'(core_val),  64'd0);
    check_eq("mid_rst_data", 64'(core_data), 64'd0);
    check_eq("mid_rst_rd",   64'({alloc_read, free_read}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    hs_log.delete();
    push_f(32'h5); push_a(32'h6);
    repeat (4) run_cycle(1'b1);
    check_log("post_rst0", 0, 1'b0, 32'h6);
    check_log("post_rst1", 1, 1'b1, 32'h5);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4) aq.push_back($urandom);
      if ($urandom_range(0, 9) < 4) fq.push_back($urandom);
      refresh_pins();
      run_cycle($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 60; i++) run_cycle(1'b1);
    check_eq("drain_aq",  64'(aq.size()), 64'd0);
    check_eq("drain_fq",  64'(fq.size()), 64'd0);
    check_eq("drain_val", 64'(core_val),  64'd0);
    check_eq("sat_acnt",  64'(alloc_cnt), PERF ? 64'(CNT_MAX) : 64'd0);
    check_eq("sat_fcnt",  64'(free_cnt),  PERF ? 64'(CNT_MAX) : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_falafel_req_arbiter

`default_nettype wire
